// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified memory port arbiter.
//   - owner_e     : owner tag carried down the response delay line
//                   (OWN_NONE=0, OWN_IF=1, OWN_D=2)
//   - CNT_W       : width of the starvation counter (covers limits up to 15)
//   - word_addr() : byte address -> word-aligned address (low 2 bits cleared)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int CNT_W = 4;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_port_arb_tagpipe.sv
// mem_port_arb_tagpipe
//   DEPTH-stage shift register of owner tags. A tag pushed in the cycle a
//   request is issued appears on o_tail exactly DEPTH cycles later, lining
//   up with the memory read data.
// Ports
//   clk    in  clock
//   rst    in  synchronous reset, active-high; clears every stage to OWN_NONE
//   i_push in  tag entering the line this cycle
//   o_tail out tag leaving the line (registered)
module mem_port_arb_tagpipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_e i_push,
  output owner_e o_tail
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      owner_e r_tag;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) r_tag <= OWN_NONE;
          else     r_tag <= i_push;
        end
      end else begin : g_shift
        always_ff @(posedge clk) begin
          if (rst) r_tag <= OWN_NONE;
          else     r_tag <= g_stage[gi-1].r_tag;
        end
      end
    end
  endgenerate

  assign o_tail = g_stage[DEPTH-1].r_tag;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port between instruction fetch (IF) and
//   data access (D). At most one request is granted and issued per cycle;
//   read data is routed back to its owner MEM_LATENCY cycles later.
//   Default arbitration: D wins, but after STARVE_LIMIT consecutive D grants
//   with IF waiting, IF is forced through for one grant.
//   Build option MEM_PORT_ARB_RR_EN: strict round-robin on conflict
//   (last-owner flop, reset to D) replaces priority + starvation counter.
// Ports
//   clk, rst                      clock / synchronous active-high reset
//   if_req, if_addr               fetch request and byte address
//   if_gnt                        fetch accepted (combinational)
//   if_rvalid, if_rdata           fetch response
//   d_req, d_addr, d_we, d_wdata  data request (d_we==0 is a read)
//   d_gnt                         data accepted (combinational)
//   d_rvalid, d_rdata             data read response (never for writes)
//   mem_en, mem_addr, mem_we, mem_d  memory command (word address)
//   mem_q                         memory read data, MEM_LATENCY after mem_en
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_d,
  input  logic [31:0] mem_q
);

  logic   w_if_pick;
  logic   w_d_pick;
  logic   w_if_gnt;
  logic   w_d_gnt;
  owner_e w_push;
  owner_e w_tail;

`ifdef MEM_PORT_ARB_RR_EN
  owner_e r_last_owner;
  logic   w_conflict;

  // On conflict the side that did not win last time gets the port.
  assign w_conflict = if_req & d_req;
  assign w_if_pick  = w_conflict ? (r_last_owner == OWN_D) : if_req;
  assign w_d_pick   = w_conflict ? (r_last_owner != OWN_D) : d_req;

  always_ff @(posedge clk) begin
    if (rst)           r_last_owner <= OWN_D;
    else if (w_if_gnt) r_last_owner <= OWN_IF;
    else if (w_d_gnt)  r_last_owner <= OWN_D;
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_if;

  // D normally wins (older instruction first); a saturated counter hands
  // one grant to a waiting fetch so IF cannot starve forever.
  assign w_force_if = if_req & (r_starve_cnt == LIMIT);
  assign w_d_pick   = d_req & ~w_force_if;
  assign w_if_pick  = if_req & ~w_d_pick;

  always_ff @(posedge clk) begin
    if (rst)                        r_starve_cnt <= '0;
    else if (!if_req || w_if_gnt)   r_starve_cnt <= '0;
    else if (w_d_gnt && r_starve_cnt != LIMIT)
                                    r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`endif

  // Grants stay combinational but are held off for the whole reset cycle.
  assign w_if_gnt = ~rst & w_if_pick;
  assign w_d_gnt  = ~rst & w_d_pick;
  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;

  // Memory command mux; everything is zero when idle.
  always_comb begin
    mem_en   = w_if_gnt | w_d_gnt;
    mem_addr = '0;
    mem_we   = '0;
    mem_d    = '0;
    if (w_d_gnt) begin
      mem_addr = word_addr(d_addr);
      mem_we   = d_we;
      mem_d    = (d_we != 4'b0000) ? d_wdata : '0;
    end else if (w_if_gnt) begin
      mem_addr = word_addr(if_addr);
    end
  end

  // Writes produce no response, so they push an empty tag.
  always_comb begin
    w_push = OWN_NONE;
    if (w_if_gnt)                        w_push = OWN_IF;
    else if (w_d_gnt && d_we == 4'b0000) w_push = OWN_D;
  end

  mem_port_arb_tagpipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tagpipe (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .o_tail (w_tail)
  );

  assign if_rvalid = (w_tail == OWN_IF);
  assign d_rvalid  = (w_tail == OWN_D);
  assign if_rdata  = if_rvalid ? mem_q : '0;
  assign d_rdata   = d_rvalid  ? mem_q : '0;

endmodule
